// File: rtl/sim_usb_rx_packet_checker.sv
// sim_usb_rx_packet_checker
// Receives a USB packet byte stream (PID first), buffers the bytes that follow
// the PID, and holds a result (PID, length, error flags) until acknowledged.
// Optional feature: define SIM_RX_CHECKER_CRC_EN to enable CRC5/CRC16 checking;
// without it no CRC logic is built and crcErr is tied low.
module sim_usb_rx_packet_checker #(
  parameter int MAX_BYTES = 64
) (
  input  logic                             CLK,
  input  logic                             RSTn,
  input  logic                             rxDataValid,
  input  logic                             rxIsLastByte,
  input  logic [7:0]                       rxData,
  output logic                             rxAcceptNewData,
  output logic                             pktDone,
  input  logic                             statusAck,
  output logic [3:0]                       pktPid,
  output logic [$clog2(MAX_BYTES+1)-1:0]   pktLen,
  output logic                             pidErr,
  output logic                             crcErr,
  output logic                             overflow,
  input  logic [$clog2(MAX_BYTES)-1:0]     rdAddr,
  output logic [7:0]                       rdData
);
  localparam int LEN_W  = $clog2(MAX_BYTES+1);
  localparam int ADDR_W = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_DROP   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_pid;
  logic [3:0]         w_pid_nxt;
  logic               r_pid_err;
  logic               w_pid_err_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               w_xfer;
  logic               w_ack;
  logic               w_full;
  logic               w_wr_en;
  logic               w_to_report;
  logic [7:0]         r_buf [MAX_BYTES];

  // A byte moves only when upstream offers it and we are not holding a result.
  assign w_xfer      = rxDataValid && (r_state != S_REPORT);
  assign w_ack       = statusAck && (r_state == S_REPORT);
  assign w_to_report = w_xfer && rxIsLastByte;
  assign w_full      = (r_len == LEN_W'(MAX_BYTES));

  assign rxAcceptNewData = (r_state != S_REPORT);
  assign pktDone         = (r_state == S_REPORT);
  assign pktPid          = r_pid;
  assign pktLen          = r_len;
  assign pidErr          = r_pid_err;
  assign overflow        = r_ovf;
  assign rdData          = r_buf[rdAddr];

  // Next-state decode for the packet FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = rxIsLastByte ? S_REPORT : S_DATA;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_to_report) begin
          w_state_nxt = S_REPORT;
        end else if (w_xfer && w_full) begin
          w_state_nxt = S_DROP;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_DROP: begin
        if (w_to_report) begin
          w_state_nxt = S_REPORT;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_REPORT: begin
        if (statusAck) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REPORT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the result registers and the buffer write strobe.
  always_comb begin
    w_pid_nxt     = r_pid;
    w_pid_err_nxt = r_pid_err;
    w_len_nxt     = r_len;
    w_ovf_nxt     = r_ovf;
    w_wr_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_pid_nxt     = rxData[3:0];
          w_pid_err_nxt = (rxData[7:4] != ~rxData[3:0]);
          w_len_nxt     = {LEN_W{1'b0}};
          w_ovf_nxt     = 1'b0;
        end else begin
          w_pid_nxt     = r_pid;
        end
      end
      S_DATA: begin
        if (w_xfer && w_full) begin
          w_ovf_nxt = 1'b1;
        end else if (w_xfer) begin
          w_wr_en   = 1'b1;
          w_len_nxt = r_len + LEN_W'(1);
        end else begin
          w_len_nxt = r_len;
        end
      end
      S_REPORT: begin
        if (statusAck) begin
          w_len_nxt     = {LEN_W{1'b0}};
          w_ovf_nxt     = 1'b0;
          w_pid_err_nxt = 1'b0;
        end else begin
          w_len_nxt     = r_len;
        end
      end
      default: w_len_nxt = r_len;
    endcase
  end

  // FSM state and result registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_pid     <= 4'd0;
      r_pid_err <= 1'b0;
      r_len     <= {LEN_W{1'b0}};
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pid     <= w_pid_nxt;
      r_pid_err <= w_pid_err_nxt;
      r_len     <= w_len_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  // Payload buffer; contents are don't-care after reset so it has no reset.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_buf[r_len[ADDR_W-1:0]] <= rxData;
    end
  end

`ifdef SIM_RX_CHECKER_CRC_EN
  logic [4:0]  r_crc5;
  logic [4:0]  w_crc5_nxt;
  logic [15:0] r_crc16;
  logic [15:0] w_crc16_nxt;
  logic        r_crc_err;
  logic        w_crc_err_eval;

  // USB CRC5 (x^5+x^2+1) advanced by one byte, bit 0 first.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] v;
    v = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ v[4]) v = {v[3:0], 1'b0} ^ 5'h05;
      else             v = {v[3:0], 1'b0};
    end
    return v;
  endfunction

  // USB CRC16 (0x8005) advanced by one byte, bit 0 first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ v[15]) v = {v[14:0], 1'b0} ^ 16'h8005;
      else              v = {v[14:0], 1'b0};
    end
    return v;
  endfunction

  // CRC accumulators: seeded on the PID, advanced on every stored byte.
  always_comb begin
    w_crc5_nxt  = r_crc5;
    w_crc16_nxt = r_crc16;
    if ((r_state == S_IDLE) && w_xfer) begin
      w_crc5_nxt  = 5'h1F;
      w_crc16_nxt = 16'hFFFF;
    end else if (w_wr_en) begin
      w_crc5_nxt  = crc5_byte(r_crc5, rxData);
      w_crc16_nxt = crc16_byte(r_crc16, rxData);
    end else begin
      w_crc5_nxt  = r_crc5;
    end
  end

  // Verdict for the packet being closed this cycle, from the PID class.
  always_comb begin
    w_crc_err_eval = 1'b0;
    if (w_ovf_nxt) begin
      w_crc_err_eval = 1'b0;
    end else begin
      case (w_pid_nxt[1:0])
        2'b01:   w_crc_err_eval = (w_len_nxt != LEN_W'(2)) || (w_crc5_nxt != 5'b01100);
        2'b11:   w_crc_err_eval = (w_crc16_nxt != 16'h800D);
        2'b10:   w_crc_err_eval = (w_len_nxt != {LEN_W{1'b0}});
        default: w_crc_err_eval = 1'b0;
      endcase
    end
  end

  // CRC state and the held crcErr flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_crc5    <= 5'h1F;
      r_crc16   <= 16'hFFFF;
      r_crc_err <= 1'b0;
    end else begin
      r_crc5  <= w_crc5_nxt;
      r_crc16 <= w_crc16_nxt;
      if (w_to_report)  r_crc_err <= w_crc_err_eval;
      else if (w_ack)   r_crc_err <= 1'b0;
      else              r_crc_err <= r_crc_err;
    end
  end

  assign crcErr = r_crc_err;
`else
  assign crcErr = 1'b0;
`endif

endmodule

// File: tb/tb_sim_usb_rx_packet_checker.sv
`timescale 1ns/1ps
// Scoreboard bench: the stimulus process pushes the expected result of each
// packet; a monitor pops and compares whenever pktDone is presented.
module tb_sim_usb_rx_packet_checker;
  localparam int MB = 8;
  localparam int LW = $clog2(MB+1);
  localparam int AW = $clog2(MB);
`ifdef SIM_RX_CHECKER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic          CLK, RSTn, rxDataValid, rxIsLastByte, rxAcceptNewData, pktDone, statusAck;
  logic [7:0]    rxData, rdData;
  logic [3:0]    pktPid;
  logic [LW-1:0] pktLen;
  logic          pidErr, crcErr, overflow;
  logic [AW-1:0] rdAddr;

  typedef bit         bitq_t[$];
  typedef logic [7:0] byteq_t[$];
  typedef struct {
    logic [3:0] pid;
    int         len;
    bit         pid_err;
    bit         crc_err;
    bit         ovf;
    logic [7:0] data[MB];
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  sim_usb_rx_packet_checker #(.MAX_BYTES(MB)) dut (
    .CLK(CLK), .RSTn(RSTn), .rxDataValid(rxDataValid), .rxIsLastByte(rxIsLastByte),
    .rxData(rxData), .rxAcceptNewData(rxAcceptNewData), .pktDone(pktDone),
    .statusAck(statusAck), .pktPid(pktPid), .pktLen(pktLen), .pidErr(pidErr),
    .crcErr(crcErr), .overflow(overflow), .rdAddr(rdAddr), .rdData(rdData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bitq_t to_bits(input byteq_t b);
    bitq_t q;
    foreach (b[j]) for (int k = 0; k < 8; k++) q.push_back(b[j][k]);
    return q;
  endfunction

  function automatic byteq_t pack(input bitq_t bits);
    byteq_t b;
    logic [7:0] v;
    for (int j = 0; j < bits.size() / 8; j++) begin
      for (int k = 0; k < 8; k++) v[k] = bits[8*j+k];
      b.push_back(v);
    end
    return b;
  endfunction

  // Serial CRC generator over the first n wire bits.
  function automatic logic [15:0] gen_crc(input bitq_t bits, input int n, input int w,
                                          input logic [15:0] poly, input logic [15:0] init);
    logic [15:0] c, mask;
    bit fb;
    c = init;
    mask = (w == 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
    for (int i = 0; i < n; i++) begin
      fb = bits[i] ^ c[w-1];
      c  = (c << 1) & mask;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

  // Packet is wrong if the transmitted CRC field differs from the inverted
  // CRC of the preceding bits (sent most significant bit first).
  function automatic bit crc_bad(input byteq_t pkt);
    byteq_t pl = pkt[1:$];
    bitq_t bits = to_bits(pl);
    int n = pl.size();
    logic [15:0] g;
    bit bad = 1'b0;
    case (pkt[0][1:0])
      2'b01: begin
        if (n != 2) bad = 1'b1;
        else begin
          g = gen_crc(bits, 11, 5, 16'h0005, 16'h001F);
          for (int k = 0; k < 5; k++) if (bits[11+k] != !g[4-k]) bad = 1'b1;
        end
      end
      2'b11: begin
        if (n < 2) bad = 1'b1;
        else begin
          g = gen_crc(bits, 8*n-16, 16, 16'h8005, 16'hFFFF);
          for (int k = 0; k < 16; k++) if (bits[8*n-16+k] != !g[15-k]) bad = 1'b1;
        end
      end
      2'b10:   bad = (n != 0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic exp_t model(input byteq_t pkt);
    exp_t e;
    int n = pkt.size() - 1;
    e.pid     = pkt[0][3:0];
    e.pid_err = (pkt[0][7:4] != ~pkt[0][3:0]);
    e.ovf     = (n > MB);
    e.len     = e.ovf ? MB : n;
    for (int i = 0; i < MB; i++) e.data[i] = (i < e.len) ? pkt[i+1] : 8'h00;
    e.crc_err = CRC_ON && !e.ovf && crc_bad(pkt);
    return e;
  endfunction

  function automatic exp_t mk_exp(input byteq_t pkt, input logic [3:0] pid, input int len,
                                  input bit pe, input bit ce, input bit ov);
    exp_t e;
    e.pid = pid; e.len = len; e.pid_err = pe; e.crc_err = ce; e.ovf = ov;
    for (int i = 0; i < MB; i++) e.data[i] = (i < len) ? pkt[i+1] : 8'h00;
    return e;
  endfunction

  function automatic byteq_t gen_pkt();
    byteq_t p, t;
    bitq_t bits;
    logic [3:0] p4;
    logic [7:0] pb, v;
    logic [15:0] g;
    int n, idx;
    p4 = 4'($urandom);
    pb = {~p4, p4};
    if ($urandom_range(0, 7) == 0) pb = 8'($urandom);
    p.push_back(pb);
    case (pb[1:0])
      2'b01: begin
        if ($urandom_range(0, 5) == 0) begin
          n = $urandom_range(0, 4);
          for (int j = 0; j < n; j++) p.push_back(8'($urandom));
        end else begin
          for (int j = 0; j < 11; j++) bits.push_back(1'($urandom));
          g = gen_crc(bits, 11, 5, 16'h0005, 16'h001F);
          for (int k = 0; k < 5; k++) bits.push_back(!g[4-k]);
          t = pack(bits);
          foreach (t[j]) p.push_back(t[j]);
        end
      end
      2'b11: begin
        n = $urandom_range(0, 9);
        for (int j = 0; j < n; j++) begin
          v = 8'($urandom);
          for (int k = 0; k < 8; k++) bits.push_back(v[k]);
        end
        g = gen_crc(bits, 8*n, 16, 16'h8005, 16'hFFFF);
        for (int k = 0; k < 16; k++) bits.push_back(!g[15-k]);
        t = pack(bits);
        foreach (t[j]) p.push_back(t[j]);
      end
      2'b10: if ($urandom_range(0, 3) == 0) p.push_back(8'($urandom));
      default: begin
        n = $urandom_range(0, 12);
        for (int j = 0; j < n; j++) p.push_back(8'($urandom));
      end
    endcase
    if (p.size() > 1 && $urandom_range(0, 3) == 0) begin
      idx = $urandom_range(1, p.size() - 1);
      p[idx] = p[idx] ^ (8'd1 << $urandom_range(0, 7));
    end
    return p;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_pkt(input byteq_t pkt, input exp_t e);
    int i = 0;
    int waited = 0;
    bit timed_out = 1'b0;
    while (i < pkt.size() && !timed_out) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) begin
        rxDataValid = 1'b0;
      end else begin
        rxDataValid  = 1'b1;
        rxData       = pkt[i];
        rxIsLastByte = (i == pkt.size() - 1);
        if (rxAcceptNewData) begin
          if (i == pkt.size() - 1) exp_q.push_back(e);
          i++;
          waited = 0;
        end else begin
          waited++;
          if (waited > 300) timed_out = 1'b1;
        end
      end
    end
    @(negedge CLK);
    rxDataValid  = 1'b0;
    rxIsLastByte = 1'b0;
    rxData       = 8'($urandom);
    if (timed_out) chk("accept_timeout", 32'd1, 32'd0);
    else           chk("pktDone_latency", {31'd0, pktDone}, 32'd1);
  endtask

  task automatic send_exp(input byteq_t pkt, input exp_t e);
    send_pkt(pkt, e);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    int hold;
    bit first = 1'b1;
    statusAck = 1'b0;
    rdAddr    = '0;
    forever begin
      @(negedge CLK);
      if (RSTn && pktDone) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pktDone", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pktPid", {28'd0, pktPid}, {28'd0, e.pid});
          chk("pktLen", 32'(pktLen), 32'(e.len));
          chk("pidErr", {31'd0, pidErr}, {31'd0, e.pid_err});
          chk("crcErr", {31'd0, crcErr}, {31'd0, e.crc_err});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          for (int i = 0; i < e.len; i++) begin
            rdAddr = AW'(i);
            #1;
            chk("rdData", {24'd0, rdData}, {24'd0, e.data[i]});
          end
          hold = first ? 20 : $urandom_range(0, 4);
          first = 1'b0;
          for (int h = 0; h <= hold; h++) begin
            @(negedge CLK);
            chk("report_hold",
                32'({rxAcceptNewData, pktDone, pktPid, pktLen, pidErr, crcErr, overflow}),
                32'({1'b0, 1'b1, e.pid, LW'(e.len), e.pid_err, e.crc_err, e.ovf}));
          end
        end
        statusAck = 1'b1;
        @(negedge CLK);
        statusAck = 1'b0;
        chk("ack_clear", 32'({rxAcceptNewData, pktDone, pktLen, pidErr, crcErr, overflow}),
            32'({1'b1, 1'b0, LW'(0), 1'b0, 1'b0, 1'b0}));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : stim
    byteq_t p;
    RSTn = 1'b0; rxDataValid = 1'b0; rxIsLastByte = 1'b0; rxData = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset_state", 32'({pktDone, pktPid, pktLen, pidErr, crcErr, overflow, rxAcceptNewData}),
        32'({1'b0, 4'd0, LW'(0), 1'b0, 1'b0, 1'b0, 1'b1}));
    RSTn = 1'b1;

    p = '{8'hD2};                 send_exp(p, mk_exp(p, 4'd2, 0, 1'b0, 1'b0, 1'b0));
    p = '{8'h69, 8'h00, 8'h10};   send_exp(p, mk_exp(p, 4'd9, 2, 1'b0, 1'b0, 1'b0));
    p = '{8'h69, 8'h00, 8'h11};   send_exp(p, mk_exp(p, 4'd9, 2, 1'b0, CRC_ON, 1'b0));
    p = '{8'hC3, 8'h00, 8'h00};   send_exp(p, mk_exp(p, 4'd3, 2, 1'b0, 1'b0, 1'b0));
    p = '{8'hC3, 8'h00, 8'h01};   send_exp(p, mk_exp(p, 4'd3, 2, 1'b0, CRC_ON, 1'b0));
    p = '{8'hC2};                 send_exp(p, mk_exp(p, 4'd2, 0, 1'b1, 1'b0, 1'b0));
    p = '{8'hC3};
    for (int i = 0; i < 12; i++) p.push_back(8'h10 + 8'(i));
    send_exp(p, mk_exp(p, 4'd3, MB, 1'b0, 1'b0, 1'b1));

    // Reset in the middle of a data packet.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      rxDataValid = 1'b1; rxIsLastByte = 1'b0;
      rxData = (i == 0) ? 8'hC3 : 8'hA0 + 8'(i);
    end
    @(negedge CLK);
    rxDataValid = 1'b0;
    RSTn = 1'b0;
    #1;
    chk("midpkt_reset", 32'({pktDone, pktPid, pktLen, pidErr, crcErr, overflow, rxAcceptNewData}),
        32'({1'b0, 4'd0, LW'(0), 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge CLK);
    RSTn = 1'b1;
    p = '{8'h69, 8'h00, 8'h10};   send_exp(p, mk_exp(p, 4'd9, 2, 1'b0, 1'b0, 1'b0));

    for (int n = 0; n < 60; n++) begin
      p = gen_pkt();
      send_pkt(p, model(p));
    end

    for (int w = 0; w < 200; w++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !pktDone) break;
    end
    chk("drain", 32'(exp_q.size()) | {31'd0, pktDone}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sim_usb_rx_packet_checker.md
SIM_USB_RX_PACKET_CHECKER -- requirements
Module: sim_usb_rx_packet_checker

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64: buffer depth in bytes following the PID; legal range 4..128.
REQ-002 SHALL have port CLK  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port RSTn  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rxDataValid  in  1  upstream byte valid.
REQ-005 SHALL have port rxIsLastByte  in  1  current byte is last of packet.
REQ-006 SHALL have port rxData  in  8  upstream byte, LSB first on wire.
REQ-007 SHALL have port rxAcceptNewData  out  1  checker ready to take a byte.
REQ-008 SHALL have port pktDone  out  1  level; packet result valid and held.
REQ-009 SHALL have port statusAck  in  1  consumer releases held result.
REQ-010 SHALL have port pktPid  out  4  PID[3:0] of held packet.
REQ-011 SHALL have port pktLen  out  $clog2(MAX_BYTES+1)  count of bytes after PID, saturating.
REQ-012 SHALL have ports pidErr, crcErr, overflow  out  1 each  error flags of held packet.
REQ-013 SHALL have ports rdAddr  in  $clog2(MAX_BYTES), rdData  out  8: combinational buffer readback.

Function
REQ-014 SHALL transfer a byte only in a cycle with rxDataValid=1 and rxAcceptNewData=1.
REQ-015 SHALL implement states IDLE, DATA, DROP, REPORT; rxAcceptNewData=1 in IDLE/DATA/DROP, 0 in REPORT.
REQ-016 IDLE: first transferred byte SHALL be latched as PID; pidErr=1 if rxData[7:4] != ~rxData[3:0]; next state REPORT if rxIsLastByte else DATA.
REQ-017 DATA: each byte SHALL be written to buffer[pktLen] and pktLen incremented; on rxIsLastByte go to REPORT.
REQ-018 DATA: a byte arriving with pktLen==MAX_BYTES SHALL set overflow, not be written, and move to DROP (or REPORT if last).
REQ-019 DROP: bytes SHALL be accepted and discarded, pktLen frozen, until rxIsLastByte, then REPORT.
REQ-020 pktDone SHALL assert the cycle after the last byte is transferred and remain high with all result outputs stable while in REPORT.
REQ-021 REPORT with statusAck=1 SHALL return to IDLE next cycle, clearing pktDone, pktLen, and error flags; statusAck outside REPORT SHALL be ignored.
REQ-022 CRC class by PID[1:0]: 01 token -> CRC5 over all bytes after PID, residual 5'b01100 required; 11 data -> CRC16 (poly 0x8005, init 0xFFFF) over all bytes after PID, residual 16'h800D required; 10 handshake -> crcErr=1 if pktLen!=0; 00 special -> no check.
REQ-023 CRC SHALL be updated per byte in one cycle, bits processed LSB first; token with pktLen!=2 SHALL set crcErr.
REQ-024 Overflowed packets SHALL report crcErr=0 (unchecked); pidErr SHALL still be evaluated.
REQ-025 A single-byte packet (PID only, last) SHALL reach REPORT with pktLen=0 without visiting DATA.

Reset
REQ-026 RSTn=0 SHALL asynchronously force IDLE, pktDone=0, pktPid=0, pktLen=0, pidErr=crcErr=overflow=0; buffer contents undefined.
REQ-027 Reset mid-packet SHALL discard the partial packet; the first byte after release is treated as a PID.

Configuration
REQ-028 With SIM_RX_CHECKER_CRC_EN defined SHALL implement REQ-022/REQ-023 checking.
REQ-029 Without SIM_RX_CHECKER_CRC_EN SHALL omit all CRC logic and tie crcErr to 0; all other behaviour unchanged.

Verification
REQ-030 Bytes 0xD2 (last) -> pktDone next cycle, pktPid=2, pktLen=0, all errors 0.
REQ-031 IN token 0x69,0x00,0x10 -> pktPid=9, pktLen=2, crcErr=0; with 0x11 as last byte -> crcErr=1 (macro defined).
REQ-032 DATA0 0xC3,0x00,0x00 -> pktLen=2, crcErr=0; 0xC3,0x00,0x01 -> crcErr=1; macro undefined -> crcErr=0 both.
REQ-033 PID byte 0xC2 -> pidErr=1; MAX_BYTES=8 with PID + 12 bytes -> overflow=1, pktLen=8, buffer[0..7] = first 8 bytes.
REQ-034 Hold statusAck=0 for 20 cycles in REPORT -> rxAcceptNewData=0, outputs stable; pulse statusAck -> IDLE; RSTn low mid-DATA -> pktDone=0, next packet decoded correctly.
